// File: rtl/seven_seg_scan.sv
// Time-multiplexed 4-digit common-anode seven-segment scanner with guard gaps between digits.
// Optional leading-zero blanking is enabled by defining SEVEN_SEG_LZB_EN.
module seven_seg_scan #(
   parameter int unsigned REFRESH_DIV = 50000,
   parameter int unsigned GAP_CYCLES  = 4,
   parameter int unsigned CNT_W       = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [3:0] hezar_in,
   input  logic [3:0] sad_in,
   input  logic [3:0] dah_in,
   input  logic [3:0] yek_in,
   input  logic [3:0] dp_in,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       frame_tick
);

   localparam logic [CNT_W-1:0] ShowLast = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] GapLast  = CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

   typedef enum logic {StShow, StGap} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       idx_q, idx_d;
   logic             wrap_q, wrap_d;
   logic [3:0]       dig_q [4];
   logic [3:0]       dpm_q;
   logic [3:0]       an_d;
   logic [6:0]       seg_d;
   logic             dp_d;
   logic [3:0]       blank;

   function automatic logic [6:0] decode(input logic [3:0] v);
      case (v)
         4'd0:    decode = 7'h40;
         4'd1:    decode = 7'h79;
         4'd2:    decode = 7'h24;
         4'd3:    decode = 7'h30;
         4'd4:    decode = 7'h19;
         4'd5:    decode = 7'h12;
         4'd6:    decode = 7'h02;
         4'd7:    decode = 7'h78;
         4'd8:    decode = 7'h00;
         4'd9:    decode = 7'h10;
         default: decode = 7'h3F;
      endcase
   endfunction

`ifdef SEVEN_SEG_LZB_EN
   logic lz3, lz2, lz1;
   // A digit is blank only while every more-significant digit is blank too.
   always_comb begin
      lz3   = (dig_q[3] == 4'd0);
      lz2   = lz3 && (dig_q[2] == 4'd0);
      lz1   = lz2 && (dig_q[1] == 4'd0);
      blank = {lz3, lz2, lz1, 1'b0};
   end
`else
   always_comb begin
      blank = 4'b0000;
   end
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      idx_d   = idx_q;
      wrap_d  = 1'b0;
      an_d    = 4'b1111;
      seg_d   = 7'h7F;
      dp_d    = 1'b1;
      case (state_q)
         StShow: begin
            if (!blank[idx_q]) begin
               an_d  = ~(4'b0001 << idx_q);
               seg_d = decode(dig_q[idx_q]);
               dp_d  = ~dpm_q[idx_q];
            end
            if (cnt_q == ShowLast) begin
               cnt_d = '0;
               if (GAP_CYCLES == 0) begin
                  idx_d  = idx_q + 2'd1;
                  wrap_d = (idx_q == 2'd3);
               end else begin
                  state_d = StGap;
               end
            end
         end
         StGap: begin
            if (cnt_q == GapLast) begin
               cnt_d   = '0;
               idx_d   = idx_q + 2'd1;
               wrap_d  = (idx_q == 2'd3);
               state_d = StShow;
            end
         end
         default: state_d = StShow;
      endcase
   end

   // Outputs are registered from the pre-edge state, so frame_tick trails wrap_q by one edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StShow;
         cnt_q      <= '0;
         idx_q      <= 2'd0;
         wrap_q     <= 1'b0;
         dig_q      <= '{default: 4'd0};
         dpm_q      <= 4'd0;
         an         <= 4'b1111;
         seg        <= 7'h7F;
         dp         <= 1'b1;
         frame_tick <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         wrap_q     <= wrap_d;
         an         <= an_d;
         seg        <= seg_d;
         dp         <= dp_d;
         frame_tick <= wrap_q;
         if (load) begin
            dig_q[3] <= hezar_in;
            dig_q[2] <= sad_in;
            dig_q[1] <= dah_in;
            dig_q[0] <= yek_in;
            dpm_q    <= dp_in;
         end
      end
   end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench for seven_seg_scan: two instances (with and without guard gap) checked
// every cycle against a cycle-count based reference model.
module tb_seven_seg_scan;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       load = 1'b0;
   logic [3:0] hezar_in = '0, sad_in = '0, dah_in = '0, yek_in = '0, dp_in = '0;
   logic [3:0] an_a, an_b;
   logic [6:0] seg_a, seg_b;
   logic       dp_a, dp_b, ft_a, ft_b;

   always #5 clk = ~clk;

   seven_seg_scan #(.REFRESH_DIV(4), .GAP_CYCLES(1), .CNT_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .load(load), .hezar_in(hezar_in), .sad_in(sad_in),
      .dah_in(dah_in), .yek_in(yek_in), .dp_in(dp_in), .an(an_a), .seg(seg_a), .dp(dp_a),
      .frame_tick(ft_a)
   );

   seven_seg_scan #(.REFRESH_DIV(2), .GAP_CYCLES(0), .CNT_W(16)) dut_b (
      .clk(clk), .rst_n(rst_n), .load(load), .hezar_in(hezar_in), .sad_in(sad_in),
      .dah_in(dah_in), .yek_in(yek_in), .dp_in(dp_in), .an(an_b), .seg(seg_b), .dp(dp_b),
      .frame_tick(ft_b)
   );

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       ft;
   } out_t;

   typedef struct packed {
      out_t a;
      out_t b;
   } exp_t;

   localparam logic [6:0] DEC [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

   exp_t q[$];
   int   total = 0;
   int   bad = 0;

   // Reference model state: edges since reset release, and the latched digits.
   int          m_t = 0;
   logic [15:0] m_dig = '0;
   logic [3:0]  m_dpm = '0;

   function automatic out_t model(input int r, input int g, input int t, input logic rst,
                                  input logic [15:0] digs, input logic [3:0] dpm);
      out_t o;
      int   period, p, k, w;
      logic [3:0] blank;
      o = '{an: 4'b1111, seg: 7'h7F, dp: 1'b1, ft: 1'b0};
      if (!rst) return o;
      blank = 4'b0000;
`ifdef SEVEN_SEG_LZB_EN
      for (int j = 3; j >= 1; j--) begin
         if (digs[j*4 +: 4] != 4'd0) break;
         blank[j] = 1'b1;
      end
`endif
      period = r + g;
      p = t % (4 * period);
      k = p / period;
      w = p % period;
      o.ft = (t != 0) && (p == 0);
      if (w < r && !blank[k]) begin
         o.an  = ~(4'(1) << k);
         o.seg = DEC[digs[k*4 +: 4]];
         o.dp  = ~dpm[k];
      end
      return o;
   endfunction

   task automatic check(input string name, input logic [6:0] act, input logic [6:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   // Drive one cycle of stimulus and queue what each DUT must show after the next edge.
   task automatic cyc(input logic r, input logic l, input logic [15:0] digs, input logic [3:0] dpv);
      exp_t e;
      @(negedge clk);
      rst_n    = r;
      load     = l;
      hezar_in = digs[15:12];
      sad_in   = digs[11:8];
      dah_in   = digs[7:4];
      yek_in   = digs[3:0];
      dp_in    = dpv;
      e.a = model(4, 1, m_t, r, m_dig, m_dpm);
      e.b = model(2, 0, m_t, r, m_dig, m_dpm);
      q.push_back(e);
      if (!r) begin
         m_t   = 0;
         m_dig = '0;
         m_dpm = '0;
      end else begin
         m_t++;
         if (l) begin
            m_dig = digs;
            m_dpm = dpv;
         end
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, $urandom, 4'($urandom));
   endtask

   function automatic logic [3:0] rdig();
      return ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
   endfunction

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            check("a_an", 7'(an_a), 7'(e.a.an));
            check("a_seg", seg_a, e.a.seg);
            check("a_dp", 7'(dp_a), 7'(e.a.dp));
            check("a_frame_tick", 7'(ft_a), 7'(e.a.ft));
            check("b_an", 7'(an_b), 7'(e.b.an));
            check("b_seg", seg_b, e.b.seg);
            check("b_dp", 7'(dp_b), 7'(e.b.dp));
            check("b_frame_tick", 7'(ft_b), 7'(e.b.ft));
         end
      end
   end

   initial begin : driver
      logic [15:0] d;
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 16'h0000, 4'h0);
      run(42);
      cyc(1'b1, 1'b1, 16'h1234, 4'b0010);
      run(22);
      cyc(1'b1, 1'b1, 16'h000C, 4'b0000);
      run(22);
      cyc(1'b1, 1'b1, 16'h0007, 4'b1111);
      run(22);
      cyc(1'b1, 1'b1, 16'h0000, 4'b0001);
      run(22);
      // Load on a reset edge must be discarded.
      cyc(1'b0, 1'b1, 16'h9876, 4'b1111);
      run(22);
      // Reset while index 2 is being shown, then confirm a clean restart.
      cyc(1'b1, 1'b1, 16'h5678, 4'b0100);
      run(10);
      cyc(1'b0, 1'b0, 16'h0000, 4'h0);
      run(22);
      for (int i = 0; i < 800; i++) begin
         d = {rdig(), rdig(), rdig(), rdig()};
         cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 7) == 0), d, 4'($urandom));
      end
      @(negedge clk);
      @(negedge clk);
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL queue_drain actual=%0d required=0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
